// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencer for an N-bit right-shift register.
// After a start request it drives one load cycle and then exactly shamt shift cycles.
// shamt is clamped to N. Completion is signalled with a one-cycle done pulse.
// All outputs are decoded from registered state, so no input has a combinational path to an output.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add an 'abort' input.
// That input cancels a running job from LOAD or SHIFT without a done pulse.
module shift_seq_ctrl #(
  parameter int N = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N-1:0]             operand,
  input  logic [$clog2(N+1)-1:0]   shamt,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic                     load_en,
  output logic                     shift_en,
  output logic [N-1:0]             data_in,
  output logic [$clog2(N+1)-1:0]   remaining
);

  localparam int SW = $clog2(N+1);

  // Three-bit encoding leaves unused codes; any of them falls back to IDLE.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  localparam logic [SW-1:0] SMAX = SW'(N);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Requests beyond the register width behave exactly like a full-width shift.
  function automatic logic [SW-1:0] clamp_shamt(input logic [SW-1:0] s);
    if (int'(s) > N) begin
      return SMAX;
    end
    return s;
  endfunction

  // Next-state decode; remaining already holds the clamped count when LOAD is entered.
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        if (abort_req)               state_nx = S_IDLE;
        else if (remaining == '0)    state_nx = S_DONE;
        else                         state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort_req)                     state_nx = S_IDLE;
        else if (remaining <= SW'(1))      state_nx = S_DONE;
        else                               state_nx = S_SHIFT;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand capture on accept and shift countdown; the counter never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_in   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            data_in   <= operand;
            remaining <= clamp_shamt(shamt);
          end
        end
        S_LOAD: begin
          if (abort_req) remaining <= '0;
        end
        S_SHIFT: begin
          if (abort_req)              remaining <= '0;
          else if (remaining != '0)   remaining <= remaining - SW'(1);
        end
        default: remaining <= '0;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    ready    = (state == S_IDLE);
    busy     = (state == S_LOAD) || (state == S_SHIFT);
    done     = (state == S_DONE);
    load_en  = (state == S_LOAD);
    shift_en = (state == S_SHIFT);
  end

endmodule
